// File: rtl/char_mem_ctrl_pkg.sv
// Shared types and default geometry for the text-mode character memory controller.
// Words are opaque 32-bit cells: ASCII [7:0], foreground [19:8], background [31:20].
package char_mem_ctrl_pkg;

    localparam int DEF_COLS   = 128;
    localparam int DEF_ROWS   = 32;
    localparam int DEF_ADDR_W = 12;
    localparam int DATA_W     = 32;

    // One-hot grant bit positions shared by the arbiter and the port mux
    localparam int GNT_CPU = 0;
    localparam int GNT_ENG = 1;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_SCROLL = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_SC_RD   = 3'd2,
        ST_SC_WR   = 3'd3,
        ST_SC_FILL = 3'd4
    } state_e;

    function automatic logic is_engine_op(input op_e op);
        return (op == OP_CLEAR) || (op == OP_SCROLL);
    endfunction

endpackage

// File: rtl/char_port_arb.sv
// Two-requester port arbiter: the CPU wins by default, the engine wins the cycle
// after a CPU grant, so each side gets at least every other cycle under contention.
module char_port_arb
    import char_mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       eng_req,
    output logic [1:0] grant
);

    logic cpu_gnt_p1;
    logic eng_win;

    always_comb begin
        eng_win        = eng_req && (!cpu_req || cpu_gnt_p1);
        grant          = 2'b00;
        grant[GNT_ENG] = eng_win;
        grant[GNT_CPU] = cpu_req && !eng_win;
    end

    // Fairness bit: remembers whether the CPU owned the port last cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_gnt_p1 <= 1'b0;
        end else begin
            cpu_gnt_p1 <= grant[GNT_CPU];
        end
    end

endmodule

// File: rtl/char_mem_ctrl.sv
// Data-port controller for the character/colour memory: shares one port between
// CPU loads/stores and a clear / scroll-up-one-row engine.
module char_mem_ctrl
    import char_mem_ctrl_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] FILL_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

    state_e            state;
    state_e            state_nxt;
    op_e               op;
    logic              cmd_acc;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_inc;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_eff;
    logic              eng_rd_p1;

    logic              eng_req;
    logic              eng_we;
    logic              eng_last;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;

    logic [1:0]        grant;
    logic              cpu_gnt;
    logic              eng_gnt;
    logic              ack_rd_p1;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready && is_engine_op(op);
    assign ptr_inc   = ptr + ADDR_W'(1);
    assign cpu_gnt   = grant[GNT_CPU];
    assign eng_gnt   = grant[GNT_ENG];

    // Read data from the previous cycle's engine read is forwarded straight into
    // the write, so an uncontended scroll needs no extra cycle per word.
    assign hold_eff  = eng_rd_p1 ? mem_rdata : hold_q;

    char_port_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_req (cpu_req),
        .eng_req (eng_req),
        .grant   (grant)
    );

    // Engine state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_acc) begin
                    state_nxt = (op == OP_CLEAR) ? ST_CLR : ST_SC_RD;
                end
            end
            ST_CLR, ST_SC_FILL: begin
                if (eng_gnt && (ptr == LAST_PTR)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SC_RD: begin
                if (eng_gnt) begin
                    state_nxt = ST_SC_WR;
                end
            end
            ST_SC_WR: begin
                if (eng_gnt) begin
                    state_nxt = (ptr_inc == FILL_BASE) ? ST_SC_FILL : ST_SC_RD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_req   = (state != ST_IDLE);
        eng_we    = 1'b0;
        eng_last  = 1'b0;
        eng_addr  = ptr;
        eng_wdata = fill_q;
        case (state)
            ST_CLR, ST_SC_FILL: begin
                eng_we   = 1'b1;
                eng_last = (ptr == LAST_PTR);
            end
            ST_SC_RD: begin
                eng_addr = ptr + ROW_STEP;
            end
            ST_SC_WR: begin
                eng_we    = 1'b1;
                eng_wdata = hold_eff;
            end
            default: ;
        endcase
    end

    // Pointer advances only on granted engine writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (cmd_acc) begin
            ptr <= '0;
        end else if (eng_gnt && eng_we) begin
            ptr <= ptr_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_acc) begin
            fill_q <= cmd_fill;
        end
    end

    // Capture is unconditional in the cycle after an engine read, even when the
    // CPU owns the port that cycle, so the pending write never loses its data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_rd_p1 <= 1'b0;
            hold_q    <= '0;
        end else begin
            eng_rd_p1 <= eng_gnt && (state == ST_SC_RD);
            if (eng_rd_p1) begin
                hold_q <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done      <= 1'b0;
            cpu_ack   <= 1'b0;
            ack_rd_p1 <= 1'b0;
        end else begin
            done      <= eng_gnt && eng_last;
            cpu_ack   <= cpu_gnt;
            ack_rd_p1 <= cpu_gnt && !cpu_we;
        end
    end

    assign cpu_rdata = (cpu_ack && ack_rd_p1) ? mem_rdata : '0;

    // Port mux; with no grant the address and data hold their last values
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (eng_gnt) begin
            mem_we    = eng_we;
            mem_addr  = eng_addr;
            mem_wdata = eng_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_char_mem_ctrl.sv
// Self-checking bench for char_mem_ctrl: behavioural memory on the data port,
// expected results derived from the clear/scroll rules and arbitration timing.
module tb_char_mem_ctrl;

    localparam int COLS  = 128;
    localparam int CELLS = 4096;
    localparam int FBASE = 3968;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_fill = '0;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:CELLS-1];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    int          done_cyc;
    int          n_ack;
    int          lost;
    int          g;
    int          k;
    int          n_done;
    bit          done_seen;
    logic [31:0] fill;
    logic [31:0] d;
    logic [31:0] expv;
    logic [11:0] rd_addr;

    char_mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_fill  (cmd_fill),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, read-before-write
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [31:0] f);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_fill  = f;
        cyc       = 0;
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Fill memory with word = address through back-to-back CPU writes
    task automatic preload();
        int n = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        for (int t = 0; t < 5000 && cpu_req; t++) begin
            tick();
            if (cpu_ack) begin
                n++;
                if (n == CELLS) begin
                    cpu_req = 1'b0; cpu_we = 1'b0;
                end else begin
                    cpu_addr = 12'(n); cpu_wdata = 32'(n);
                end
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        chk("preload_count", 32'(n), 32'(CELLS));
    endtask

    task automatic cpu_read(input logic [11:0] a, output logic [31:0] data);
        int t = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        do begin
            tick();
            t++;
        end while (!cpu_ack && t < 16);
        data = cpu_rdata;
        cpu_req = 1'b0;
        chk("rd_latency", 32'(t), 32'd1);
    endtask

    task automatic check_fill_mem(input string tag, input logic [31:0] f);
        for (int a = 0; a < CELLS; a++) chk(tag, mem[a], f);
    endtask

    task automatic check_scroll_mem(input string tag, input logic [31:0] f);
        for (int a = 0; a < CELLS; a++) chk(tag, mem[a], (a < FBASE) ? 32'(a + COLS) : f);
    endtask

    // Uncontended CLEAR: one write per cycle at 0..4095, SCROLL offered mid-way is ignored
    task automatic run_clear(input logic [31:0] f);
        int dc = 0;
        start_cmd(2'd1, f);
        while (cyc < 4200 && dc == 0) begin
            if (done) begin
                dc = cyc;
            end else begin
                chk("clr_we", 32'(mem_we), 32'd1);
                chk("clr_addr", 32'(mem_addr), 32'(cyc - 1));
                chk("clr_wdata", mem_wdata, f);
                if (cyc == 100) begin
                    cmd_valid = 1'b1; cmd_op = 2'd2;
                    chk("clr_busy_ready", 32'(cmd_ready), 32'd0);
                end else begin
                    cmd_valid = 1'b0;
                end
                tick();
            end
        end
        cmd_valid = 1'b0;
        chk("clr_done_cycle", 32'(dc), 32'd4097);
        chk("clr_busy_fall", 32'(busy), 32'd0);
        chk("clr_ready_back", 32'(cmd_ready), 32'd1);
        tick();
        chk("clr_done_pulse", 32'(done), 32'd0);
        check_fill_mem("clr_mem", f);
    endtask

    initial begin
        // Reset with a command offered throughout
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_fill = 32'h1234_5678;
        repeat (3) tick();
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) tick();
        chk("rst_cmd_ignored", 32'(busy), 32'd0);

        // NOP and reserved ops are ignored
        cmd_valid = 1'b1; cmd_op = 2'd0;
        tick();
        chk("nop_ignored", 32'(busy), 32'd0);
        cmd_op = 2'd3;
        tick();
        cmd_valid = 1'b0;
        chk("rsvd_ignored", 32'(busy), 32'd0);
        chk("rsvd_ready", 32'(cmd_ready), 32'd1);

        // CPU writes then random idle reads; address holds after the access
        preload();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 12'($urandom_range(0, CELLS - 1));
            cpu_read(rd_addr, d);
            chk("idle_rdata", d, 32'(rd_addr));
            chk("idle_addr_hold", 32'(mem_addr), 32'(rd_addr));
            chk("idle_we_low", 32'(mem_we), 32'd0);
        end

        run_clear(32'h00F0F020);

        // CLEAR under continuous CPU reads: strict alternation from cycle 1
        preload();
        fill = $urandom | 32'h8000_0000;
        start_cmd(2'd1, fill);
        rd_addr = 12'($urandom_range(0, CELLS - 1));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rd_addr;
        done_cyc = 0; n_ack = 0;
        while (cpu_req && cyc < 8400) begin
            tick();
            if (done && done_cyc == 0) done_cyc = cyc;
            if (cpu_ack) begin
                g = cyc - 1;
                expv = (2 * int'(rd_addr) + 2 < g) ? fill : 32'(rd_addr);
                chk("cclr_rdata", cpu_rdata, expv);
                n_ack++;
                if (done_cyc != 0) begin
                    cpu_req = 1'b0;
                end else begin
                    rd_addr = 12'($urandom_range(0, CELLS - 1));
                    cpu_addr = rd_addr;
                end
            end
        end
        cpu_req = 1'b0;
        chk("cclr_done_cycle", 32'(done_cyc), 32'd8193);
        chk("cclr_ack_count", 32'(n_ack), 32'd4097);
        check_fill_mem("cclr_mem", fill);

        // Uncontended SCROLL: read/write pairs then bottom-row fill
        preload();
        fill = $urandom | 32'h8000_0000;
        start_cmd(2'd2, fill);
        done_cyc = 0;
        while (cyc < 8200 && done_cyc == 0) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (cyc <= 2 * FBASE) begin
                    k = (cyc - 1) / 2;
                    if (cyc % 2 == 1) begin
                        chk("scr_rd_we", 32'(mem_we), 32'd0);
                        chk("scr_rd_addr", 32'(mem_addr), 32'(k + COLS));
                    end else begin
                        chk("scr_wr_we", 32'(mem_we), 32'd1);
                        chk("scr_wr_addr", 32'(mem_addr), 32'(k));
                        chk("scr_wr_data", mem_wdata, 32'(k + COLS));
                    end
                end else begin
                    chk("scr_fill_we", 32'(mem_we), 32'd1);
                    chk("scr_fill_addr", 32'(mem_addr), 32'(FBASE + cyc - 2 * FBASE - 1));
                    chk("scr_fill_data", mem_wdata, fill);
                end
                tick();
            end
        end
        chk("scr_done_cycle", 32'(done_cyc), 32'd8065);
        check_scroll_mem("scr_mem", fill);

        // SCROLL with random CPU reads: every CPU grant while busy costs one cycle
        preload();
        fill = $urandom | 32'h8000_0000;
        start_cmd(2'd2, fill);
        done_seen = 1'b0; done_cyc = 0; lost = 0;
        while ((!done_seen || cpu_req) && cyc < 20000) begin
            if (!cpu_req && !done_seen && $urandom_range(0, 1) == 1) begin
                cpu_req = 1'b1; cpu_we = 1'b0;
                cpu_addr = 12'($urandom_range(0, CELLS - 1));
            end
            tick();
            if (cpu_ack) begin
                if (!done_seen) lost++;
                cpu_req = 1'b0;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc = cyc;
            end
        end
        cpu_req = 1'b0;
        chk("cscr_done_cycle", 32'(done_cyc), 32'(8065 + lost));
        check_scroll_mem("cscr_mem", fill);

        // Reset in the middle of a SCROLL, then a normal CLEAR
        start_cmd(2'd2, 32'h0BAD_F00D);
        n_done = 0;
        while (cyc < 2000) begin
            if (done) n_done++;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_we", 32'(mem_we), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("mid_no_done", 32'(n_done), 32'd0);
        run_clear(32'h0020_0F41);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
